bus_mux_reg: RTL
================

BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16, width of every source channel and of data_out.
REQ-002 SHALL have parameter NUM_SRC, default 10, number of source channels.
REQ-003 SHALL have parameter MUX_SEL_SIG, default 4, width of select; 2**MUX_SEL_SIG >= NUM_SRC is required.
REQ-004 SHALL have parameter ERR_CNT_LEN, default 8, width of err_count.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port src_bus, input, NUM_SRC*DATA_LEN, flattened sources; channel k occupies bits [k*DATA_LEN +: DATA_LEN].
REQ-008 SHALL have port sel_valid, input, 1, select request present.
REQ-009 SHALL have port select, input, MUX_SEL_SIG, channel index of the request.
REQ-010 SHALL have port sel_ready, output, 1, request is accepted this cycle.
REQ-011 SHALL have port data_out, output, DATA_LEN, registered selected word.
REQ-012 SHALL have port out_valid, output, 1, data_out holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1, consumer takes data_out this cycle.
REQ-014 SHALL have port sel_err, output, 1, one-cycle pulse on an out-of-range request.
REQ-015 SHALL have port err_count, output, ERR_CNT_LEN, saturating count of out-of-range requests.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no held word), FULL (held word, out_valid=1).
REQ-017 SHALL drive sel_ready=1 in IDLE and sel_ready=out_ready in FULL (combinational).
REQ-018 SHALL treat a request as accepted when sel_valid and sel_ready are both 1 at a rising edge.
REQ-019 SHALL, on an accepted request with select < NUM_SRC, load src_bus channel select into data_out at that edge and be in FULL the next cycle (latency 1 cycle).
REQ-020 SHALL snapshot the source at acceptance; later src_bus changes SHALL NOT alter data_out.
REQ-021 SHALL, on an accepted request with select >= NUM_SRC, leave data_out unchanged, enter IDLE, assert sel_err for exactly the next cycle and increment err_count.
REQ-022 SHALL hold err_count at all-ones once reached (no wrap).
REQ-023 SHALL, in FULL with out_ready=1 and sel_valid=0, enter IDLE; out_valid=0 next cycle, data_out retains its last value.
REQ-024 SHALL, in FULL with out_ready=1 and a valid in-range request, reload data_out and stay FULL (back-to-back, one word per cycle).
REQ-025 SHALL, in FULL with out_ready=0, hold data_out and out_valid stable regardless of sel_valid, select or src_bus.
REQ-026 SHALL, in IDLE, ignore out_ready.
REQ-027 SHALL assert out_valid exactly when state is FULL.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, data_out=0, out_valid=0, sel_err=0, err_count=0, independent of clk.
REQ-029 SHALL discard any held word when rst asserts mid-transaction; no request is accepted while rst=1.
REQ-030 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover: reset, channel 3=16'h1234, sel_valid=1 select=3 for one edge -> next cycle data_out=16'h1234, out_valid=1.
REQ-032 SHALL cover: FULL with 16'h1234, out_ready=0 for 5 cycles while channel 3 changes to 16'hFFFF and new requests arrive -> data_out stays 16'h1234, sel_ready=0.
REQ-033 SHALL cover: out_ready=1 continuously, requests select=0,1,2 on consecutive edges with channels 16'hA000,16'hA001,16'hA002 -> data_out A000,A001,A002 on consecutive cycles, out_valid=1 throughout.
REQ-034 SHALL cover: IDLE, select=4'hC (>= NUM_SRC=10) accepted -> sel_err=1 for one cycle, err_count=1, out_valid=0, data_out unchanged.
REQ-035 SHALL cover: ERR_CNT_LEN=2, five invalid requests -> err_count 1,2,3,3,3.
REQ-036 SHALL cover: rst pulsed between clock edges while FULL -> out_valid=0 and data_out=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: selects one of NUM_SRC source words on a valid/ready request and holds it
// in an output register until the consumer takes it; out-of-range requests are counted.
module bus_mux_reg #(
    parameter int DATA_LEN    = 16,
    parameter int NUM_SRC     = 10,
    parameter int MUX_SEL_SIG = 4,
    parameter int ERR_CNT_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*DATA_LEN-1:0]  src_bus,
    input  logic                         sel_valid,
    input  logic [MUX_SEL_SIG-1:0]       select,
    output logic                         sel_ready,
    output logic [DATA_LEN-1:0]          data_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sel_err,
    output logic [ERR_CNT_LEN-1:0]       err_count
);
    typedef enum logic {IDLE, FULL} state_t;
    state_t                 state_q, state_d;
    logic [DATA_LEN-1:0]    data_q, data_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_LEN-1:0] cnt_q, cnt_d;
    logic [DATA_LEN-1:0]    ch [2**MUX_SEL_SIG];
    logic                   accept, in_range;

    // Pad the channel table to the full select range so any select value indexes safely.
    genvar g;
    for (g = 0; g < 2**MUX_SEL_SIG; g++) begin : g_ch
        if (g < NUM_SRC) begin : g_src
            assign ch[g] = src_bus[g*DATA_LEN +: DATA_LEN];
        end else begin : g_pad
            assign ch[g] = '0;
        end
    end

    assign sel_ready = (state_q == IDLE) ? 1'b1 : out_ready;
    assign accept    = sel_valid && sel_ready;
    assign in_range  = int'(select) < NUM_SRC;

    always_comb begin
        state_d = (state_q == FULL && out_ready) ? IDLE : state_q;
        data_d  = data_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (accept && in_range) begin
            state_d = FULL;
            data_d  = ch[select];
        end else if (accept) begin
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = (state_q == FULL);
    assign sel_err   = err_q;
    assign err_count = cnt_q;
endmodule
